// File: rtl/card_shoe.sv
// card_shoe: multi-deck rank source dealing without replacement.
// A free-running rank counter seeds each search; shuffle refills the shoe.
module card_shoe #(
    parameter int NUM_DECKS = 1,
    parameter int RANKS     = 13,
    parameter int SUITS     = 4
) (
    input  logic clock,
    input  logic resetb,
    input  logic shuffle,
    input  logic deal_req,
    output logic busy,
    output logic card_valid,
    output logic [3:0] card,
    output logic no_card,
    output logic shoe_empty,
    output logic [$clog2(RANKS*SUITS*NUM_DECKS+1)-1:0] cards_left
);

    localparam int TOTAL = RANKS * SUITS * NUM_DECKS;
    localparam int PER   = SUITS * NUM_DECKS;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int KW    = $clog2(PER + 1);

    localparam logic [3:0]    RMAX      = 4'(RANKS);
    localparam logic [CW-1:0] FULL_LEFT = CW'(TOTAL);
    localparam logic [KW-1:0] FULL_CNT  = KW'(PER);

    typedef enum logic {
        IDLE,
        SEARCH
    } state_t;

    state_t state;
    state_t state_n;

    logic [3:0] rank_ctr;
    logic [3:0] ptr;
    logic [3:0] ptr_n;
    logic [3:0] card_n;
    logic       valid_n;
    logic       nocard_n;
    logic       refill;
    logic       take;

    // Slots 0 and above RANKS stay zero so a 4-bit index is always legal
    logic [15:0][KW-1:0] cnt;

    function automatic logic [3:0] next_rank(input logic [3:0] r);
        return (r == RMAX) ? 4'd1 : r + 4'd1;
    endfunction

    assign busy       = (state == SEARCH);
    assign shoe_empty = (cards_left == '0);

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        card_n   = card;
        valid_n  = 1'b0;
        nocard_n = 1'b0;
        refill   = 1'b0;
        take     = 1'b0;
        unique case (state)
            IDLE: begin
                if (shuffle) begin
                    refill = 1'b1;
                end else if (deal_req && shoe_empty) begin
                    nocard_n = 1'b1;
                end else if (deal_req) begin
                    ptr_n   = rank_ctr;
                    state_n = SEARCH;
                end
            end
            SEARCH: begin
                if (shuffle) begin
                    refill  = 1'b1;
                    state_n = IDLE;
                end else if (cnt[ptr] != '0) begin
                    take    = 1'b1;
                    card_n  = ptr;
                    valid_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    ptr_n = next_rank(ptr);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            state      <= IDLE;
            rank_ctr   <= 4'd1;
            ptr        <= 4'd1;
            card       <= 4'd0;
            card_valid <= 1'b0;
            no_card    <= 1'b0;
            cards_left <= FULL_LEFT;
            for (int i = 0; i < 16; i++) begin
                cnt[i[3:0]] <= (i >= 1 && i <= RANKS) ? FULL_CNT : '0;
            end
        end else begin
            state      <= state_n;
            rank_ctr   <= next_rank(rank_ctr);
            ptr        <= ptr_n;
            card       <= card_n;
            card_valid <= valid_n;
            no_card    <= nocard_n;
            if (refill) begin
                cards_left <= FULL_LEFT;
                for (int i = 0; i < 16; i++) begin
                    cnt[i[3:0]] <= (i >= 1 && i <= RANKS) ? FULL_CNT : '0;
                end
            end else if (take) begin
                cnt[ptr]   <= cnt[ptr] - KW'(1);
                cards_left <= cards_left - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_card_shoe.sv
// Bench for card_shoe: one- and two-deck shoes driven in lockstep,
// checked every cycle against a deal-level model of the shoe.
module tb_card_shoe;

    localparam int R = 13;

    logic clock = 1'b0;
    logic resetb = 1'b0;
    logic shuffle = 1'b0;
    logic deal_req = 1'b0;

    logic       busy[2];
    logic       card_valid[2];
    logic       no_card[2];
    logic       shoe_empty[2];
    logic [3:0] card[2];
    logic [5:0] left0;
    logic [6:0] left1;

    always #5 clock = ~clock;

    card_shoe #(.NUM_DECKS(1), .RANKS(R), .SUITS(4)) u0 (
        .clock(clock), .resetb(resetb), .shuffle(shuffle),
        .deal_req(deal_req), .busy(busy[0]),
        .card_valid(card_valid[0]), .card(card[0]),
        .no_card(no_card[0]), .shoe_empty(shoe_empty[0]),
        .cards_left(left0)
    );

    card_shoe #(.NUM_DECKS(2), .RANKS(R), .SUITS(4)) u1 (
        .clock(clock), .resetb(resetb), .shuffle(shuffle),
        .deal_req(deal_req), .busy(busy[1]),
        .card_valid(card_valid[1]), .card(card[1]),
        .no_card(no_card[1]), .shoe_empty(shoe_empty[1]),
        .cards_left(left1)
    );

    // model: per-rank stock, a pending deal with its known rank and delay
    int m_ctr;
    int m_cnt[2][16];
    int m_left[2];
    bit m_srch[2];
    int m_due[2];
    int m_rank[2];
    bit e_valid[2];
    bit e_nocard[2];
    int e_card[2];
    int per[2] = '{4, 8};
    bit armed = 1'b0;

    int compared = 0;
    int mismatched = 0;
    int hist[2][16];

    task automatic refill(input int k);
        for (int r = 0; r < 16; r++) m_cnt[k][r] = (r >= 1 && r <= R) ? per[k] : 0;
        m_left[k] = R * per[k];
    endtask

    task automatic step(input int k);
        int r;
        e_valid[k] = 1'b0;
        e_nocard[k] = 1'b0;
        if (m_srch[k]) begin
            if (shuffle) begin
                refill(k);
                m_srch[k] = 1'b0;
            end else if (m_due[k] == 0) begin
                e_valid[k] = 1'b1;
                e_card[k] = m_rank[k];
                m_cnt[k][m_rank[k]]--;
                m_left[k]--;
                m_srch[k] = 1'b0;
            end else begin
                m_due[k]--;
            end
        end else if (shuffle) begin
            refill(k);
        end else if (deal_req && m_left[k] == 0) begin
            e_nocard[k] = 1'b1;
        end else if (deal_req) begin
            for (int j = 0; j < R; j++) begin
                r = ((m_ctr - 1 + j) % R) + 1;
                if (m_cnt[k][r] > 0) begin
                    m_rank[k] = r;
                    m_due[k] = j;
                    break;
                end
            end
            m_srch[k] = 1'b1;
        end
    endtask

    always @(posedge clock) begin
        if (!resetb) begin
            armed = 1'b1;
            m_ctr = 1;
            for (int k = 0; k < 2; k++) begin
                refill(k);
                m_srch[k] = 1'b0;
                e_valid[k] = 1'b0;
                e_nocard[k] = 1'b0;
                e_card[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) step(k);
            m_ctr = (m_ctr == R) ? 1 : m_ctr + 1;
        end
    end

    always @(negedge clock) begin
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                int gl;
                bit ok;
                gl = (k == 0) ? int'(left0) : int'(left1);
                ok = (busy[k] === m_srch[k])
                    && (card_valid[k] === e_valid[k])
                    && (no_card[k] === e_nocard[k])
                    && (card[k] === 4'(e_card[k]))
                    && (shoe_empty[k] === (m_left[k] == 0))
                    && (gl == m_left[k]);
                compared++;
                if (!ok) begin
                    mismatched++;
                    $display("FAIL cycle_u%0d t=%0t got b=%b v=%b nc=%b c=%0d e=%b l=%0d want b=%b v=%b nc=%b c=%0d e=%b l=%0d",
                        k, $time, busy[k], card_valid[k], no_card[k],
                        card[k], shoe_empty[k], gl, m_srch[k],
                        e_valid[k], e_nocard[k], e_card[k],
                        m_left[k] == 0, m_left[k]);
                end
                if (card_valid[k] === 1'b1) hist[k][card[k]]++;
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_ctr(input int v);
        for (int i = 0; i < 40 && m_ctr != v; i++) tick();
        if (m_ctr != v) chk("wait_ctr_timeout", m_ctr, v);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && (m_srch[0] || m_srch[1]); i++) tick();
        if (m_srch[0] || m_srch[1]) chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic pulse_deal();
        deal_req = 1'b1;
        tick();
        deal_req = 1'b0;
    endtask

    task automatic clear_hist();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 16; r++) hist[k][r] = 0;
    endtask

    initial begin
        int lat;
        clear_hist();
        repeat (3) tick();
        chk("rst_left0", int'(left0), 52);
        chk("rst_left1", int'(left1), 104);
        chk("rst_empty", int'(shoe_empty[0]), 0);
        chk("rst_card", int'(card[0]), 0);
        chk("rst_busy", int'(busy[0]), 0);
        resetb = 1'b1;

        wait_ctr(5);
        pulse_deal();
        chk("t1_busy", int'(busy[0]), 1);
        tick();
        chk("t1_valid", int'(card_valid[0]), 1);
        chk("t1_card", int'(card[0]), 5);
        chk("t1_left", int'(left0), 51);
        chk("t1_busy_off", int'(busy[0]), 0);

        for (int i = 0; i < 4; i++) begin
            wait_idle();
            wait_ctr(1);
            pulse_deal();
            tick();
            chk("ace_card", int'(card[0]), 1);
        end
        wait_idle();
        wait_ctr(1);
        pulse_deal();
        tick();
        chk("a5_early", int'(card_valid[0]), 0);
        tick();
        chk("a5_valid", int'(card_valid[0]), 1);
        chk("a5_card", int'(card[0]), 2);

        wait_idle();
        shuffle = 1'b1;
        tick();
        shuffle = 1'b0;
        chk("shuf_left", int'(left0), 52);
        clear_hist();
        deal_req = 1'b1;
        for (int i = 0; i < 3000 && m_left[0] != 0; i++) tick();
        chk("last_valid", int'(card_valid[0]), 1);
        chk("last_empty", int'(shoe_empty[0]), 1);
        tick();
        chk("empty_nocard", int'(no_card[0]), 1);
        chk("empty_novalid", int'(card_valid[0]), 0);
        chk("empty_left", int'(left0), 0);
        for (int r = 1; r <= R; r++) chk("hist1", hist[0][r], 4);
        for (int i = 0; i < 6000 && m_left[1] != 0; i++) tick();
        tick();
        deal_req = 1'b0;
        for (int r = 1; r <= R; r++) chk("hist2", hist[1][r], 8);

        shuffle = 1'b1;
        deal_req = 1'b1;
        tick();
        shuffle = 1'b0;
        deal_req = 1'b0;
        chk("sd_left", int'(left0), 52);
        chk("sd_busy", int'(busy[0]), 0);
        chk("sd_empty", int'(shoe_empty[0]), 0);
        tick();
        chk("sd_novalid", int'(card_valid[0]), 0);
        wait_ctr(3);
        pulse_deal();
        lat = 0;
        for (int i = 0; i < 20 && card_valid[0] !== 1'b1; i++) tick();
        chk("sd_deal", int'(card_valid[0]), 1);
        chk("sd_deal_left", int'(left0), 51);

        wait_idle();
        shuffle = 1'b1;
        tick();
        shuffle = 1'b0;
        for (int i = 0; i < 48; i++) begin
            wait_idle();
            wait_ctr(1);
            pulse_deal();
        end
        wait_idle();
        tick();
        chk("depl_left", int'(left0), 4);
        wait_ctr(1);
        pulse_deal();
        lat = 1;
        for (int i = 0; i < 30 && card_valid[0] !== 1'b1; i++) begin
            tick();
            lat++;
        end
        chk("skip_lat", lat, 14);
        chk("skip_card", int'(card[0]), 13);

        wait_idle();
        wait_ctr(1);
        pulse_deal();
        repeat (5) tick();
        chk("abort_busy_pre", int'(busy[0]), 1);
        shuffle = 1'b1;
        tick();
        shuffle = 1'b0;
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_left", int'(left0), 52);
        chk("abort_valid", int'(card_valid[0]), 0);

        wait_idle();
        wait_ctr(2);
        pulse_deal();
        chk("rs_busy_pre", int'(busy[0]), 1);
        resetb = 1'b0;
        tick();
        resetb = 1'b1;
        chk("rs_busy", int'(busy[0]), 0);
        chk("rs_valid", int'(card_valid[0]), 0);
        chk("rs_card", int'(card[0]), 0);
        chk("rs_left0", int'(left0), 52);
        chk("rs_left1", int'(left1), 104);

        for (int i = 0; i < 800; i++) begin
            deal_req = ($urandom_range(0, 3) != 0);
            shuffle = ($urandom_range(0, 80) == 0);
            resetb = ($urandom_range(0, 200) != 0);
            tick();
        end
        deal_req = 1'b0;
        shuffle = 1'b0;
        resetb = 1'b1;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
            compared, mismatched);
        $finish;
    end

endmodule

// File: doc/card_shoe.md
Name: card_shoe

Overview:
- Multi-deck card source for the blackjack datapath; successor to the single free-running 1..13 dealer counter.
- Deals ranks without replacement from a shoe of NUM_DECKS decks, using a free-running rank counter as the randomness source.
- Provides a request/valid handshake, a remaining-card count, empty detection, and a shuffle (refill) command.
- Sits between the player/dealer control FSM and the card-score/display logic.

Parameters:
- NUM_DECKS, default 1: decks in the shoe; legal range 1..8.
- RANKS, default 13: ranks per deck, encoded 1..RANKS; legal range 2..15, so a rank always fits in 4 bits.
- SUITS, default 4: copies of each rank per deck.

Ports:
- clock  in  1  system clock.
- resetb  in  1  reset.
- shuffle  in  1  refill request; sampled every cycle.
- deal_req  in  1  deal request; sampled only when busy=0.
- busy  out  1  high while a search is in progress.
- card_valid  out  1  one-cycle pulse; card is valid this cycle.
- card  out  4  dealt rank 1..RANKS; holds its value until the next deal.
- no_card  out  1  one-cycle pulse; request refused because the shoe is empty.
- shoe_empty  out  1  high when cards_left==0.
- cards_left  out  clog2(RANKS*SUITS*NUM_DECKS+1)  cards remaining.

Behaviour:
- Interface: reset resetb, synchronous, active-low; clock clock. All state updates on posedge clock.
- Reset values:
  - rank counter = 1.
  - Every per-rank count = SUITS*NUM_DECKS.
  - cards_left = RANKS*SUITS*NUM_DECKS.
  - state = IDLE.
  - busy = 0, card_valid = 0, no_card = 0, card = 0, shoe_empty = 0.
- Rank counter:
  - Free-running: increments every cycle, including during reset release and search.
  - Wraps RANKS -> 1. Never 0.
- Per-rank count array:
  - Indexed 1..RANKS.
  - Width clog2(SUITS*NUM_DECKS+1).
  - A count never underflows.
- shoe_empty is combinational from cards_left==0.
- FSM state IDLE:
  - If shuffle=1: refill all counts and cards_left to their reset values; stay in IDLE; ignore deal_req this cycle. Shuffle has priority.
  - Else if deal_req=1 and shoe_empty=1: pulse no_card next cycle; stay in IDLE.
  - Else if deal_req=1: latch ptr = current counter value; set busy=1; go to SEARCH.
- FSM state SEARCH (one rank examined per cycle):
  - If shuffle=1: refill; busy=0; return to IDLE. No card_valid and no decrement.
  - Else if count[ptr] > 0: decrement count[ptr] and cards_left; card <= ptr; card_valid=1 for one cycle; busy=0; return to IDLE.
  - Else: ptr <= (ptr==RANKS) ? 1 : ptr+1; stay in SEARCH.
- Latency:
  - deal_req high in cycle t (IDLE) -> card_valid in cycle t+2 when the first rank examined has stock.
  - Worst case is t+1+RANKS.
  - The search always terminates, because entry requires cards_left>0.
- deal_req is level-sensitive. Held high, it issues back-to-back deals, one accepted per IDLE cycle.
- card_valid and no_card are never high in the same cycle.
- Reset mid-search: abandon the search and restore full reset values. No card_valid pulse.
- Deal of the last card: shoe_empty rises in the same cycle as that card's card_valid.

Test Plan:
- Reset release, then deal_req pulsed when counter=5 -> card_valid at t+2 with card=5; cards_left 52->51; busy high exactly 1 cycle.
- NUM_DECKS=1: deal four requests each while counter=1 (aces) -> cards 1,1,1,1. A fifth request with counter=1 -> card=2 with card_valid at t+3.
- Hold deal_req for 52 accepted deals -> the histogram shows exactly 4 of each rank; shoe_empty=1 with the 52nd card_valid; a following request -> no_card pulse, card_valid stays 0, cards_left=0.
- Empty shoe, pulse shuffle -> cards_left=52, shoe_empty=0; the next request succeeds. Shuffle and deal_req in the same IDLE cycle -> refill only, no deal.
- Deplete ranks 1..12 then request at counter=1 -> 12-cycle skip, card=13. Assert shuffle during the 6th search cycle -> no card_valid, busy=0, cards_left=52.
- NUM_DECKS=2, RANKS=13 -> reset cards_left=104; 8 copies of each rank dealt before empty. resetb low during SEARCH -> all outputs return to reset values next cycle.
